serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled on rising edge of clk.
REQ-005 a  input  WIDTH  operand A; captured only when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured only when start is accepted.
REQ-007 cin  input  1  carry-in; captured only when start is accepted.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the MSB.

Function
REQ-012 States SHALL be IDLE, RUN, DONE; done high iff state==DONE; busy high iff state==RUN.
REQ-013 start high at edge k in IDLE or DONE: capture a, b, cin into internal shift/carry registers, clear bit counter, enter RUN.
REQ-014 RUN: one bit per edge, LSB first, computed by one full-adder cell: sum bit = a0^b0^c, carry register <= majority(a0,b0,c); operands shift right; sum bit shifts into internal result register MSB.
REQ-015 After WIDTH RUN edges (edge k+WIDTH) state SHALL be DONE; sum and cout outputs load at that same edge.
REQ-016 Latency: done high during the cycle following edge k+WIDTH, exactly one cycle; DONE -> IDLE at edge k+WIDTH+1 unless start is high.
REQ-017 start high in DONE SHALL be accepted (back-to-back operation, no idle gap); done still pulses for the finished result.
REQ-018 start while in RUN SHALL be ignored; operands and count unaffected.
REQ-019 sum and cout SHALL hold the last completed result until the next completion; they never expose partial results.
REQ-020 Bit counter SHALL be ceil(log2(WIDTH+1)) bits; no wrap-around beyond WIDTH.
REQ-021 a, b, cin changes after capture SHALL NOT affect an in-flight operation.

Reset
REQ-022 rst high SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, counter, carry and shift registers to 0.
REQ-023 rst during RUN SHALL abort the operation; no done pulse and no result update follow.
REQ-024 start sampled in the same edge that rst deasserts is ignored if rst is still high at that edge.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN defined: extra output ovf (1 bit, reset 0) = signed overflow (carry into MSB xor carry out of MSB), registered with sum/cout.
REQ-026 Macro undefined: ovf port and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-027 Shared package alu_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default constant.
REQ-028 One sub-module full_adder_cell (inputs i1, i2, cin; outputs sum, carry) SHALL be built from two half adders plus an OR; serial_adder instantiates exactly one.

Verification
REQ-029 WIDTH=8, a=0x03, b=0x05, cin=0, start one cycle -> busy 8 cycles, done pulse on 9th cycle after start edge, sum=0x08, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with SERIAL_ADDER_OVF_EN ovf=0.
REQ-031 a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0; with SERIAL_ADDER_OVF_EN ovf=1.
REQ-032 start pulses at cycles 2 and 4 of a RUN with new operands -> ignored; result matches first operands only.
REQ-033 rst asserted at RUN cycle 4 -> outputs 0 immediately, no done pulse; next start computes 0xAA+0x55=0xFF, cout=0 correctly.
REQ-034 start held high continuously with operand sets (1,1),(2,2) -> done pulses back-to-back every 9 cycles; sums 0x02 then 0x04.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the serial adder: FSM state encoding
// and the default operand width.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders and an OR.
// The serial adder reuses this single cell for every bit position.
module full_adder_cell (
    input  logic i1,
    input  logic i2,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic h1_s;
    logic h1_c;
    logic h2_c;

    // first half adder: the two operand bits
    assign h1_s = i1 ^ i2;
    assign h1_c = i1 & i2;

    // second half adder: partial sum plus incoming carry
    assign h2_c = h1_s & cin;

    assign sum   = h1_s ^ cin;
    assign carry = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles.
// Optional ovf output when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
    logic             last;

    // start is honoured only when no addition is in flight
    assign accept = start && (state_q == IDLE || state_q == DONE);
    // the WIDTH-th RUN edge finishes the operation
    assign last   = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

    full_adder_cell u_fa (
        .i1    (a_q[0]),
        .i2    (b_q[0]),
        .cin   (c_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // status outputs decoded from the state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // operand capture, bit-serial shifting and result load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            c_q   <= cin;
            res_q <= '0;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            c_q   <= fa_carry;
            res_q <= {fa_sum, res_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                sum_q  <= {fa_sum, res_q[WIDTH-1:1]};
                cout_q <= fa_carry;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // signed overflow: carry into MSB differs from carry out of MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last && !accept) begin
            ovf_q <= c_q ^ fa_carry;
        end
    end

    assign ovf = ovf_q;
`endif

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed test of serial_adder (WIDTH=8) with hand-computed
// results, covering timing, ignored starts, reset abort and back-to-back.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one full operation; operands are scrambled after capture
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tc, input logic [7:0] es,
                          input logic ec, input logic eo,
                          input logic [7:0] prev);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
        for (int i = 1; i <= 8; i++) begin
            chk1("run_busy", busy, 1'b1);
            chk1("run_done", done, 1'b0);
            chk8("run_sum_hold", sum, prev);
            @(negedge clk);
        end
        chk1("done_pulse", done, 1'b1);
        chk1("done_busy", busy, 1'b0);
        chk8("result_sum", sum, es);
        chk1("result_cout", cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
        chk1("result_ovf", ovf, eo);
`else
        if (eo === 1'bx) $display("unreachable");
`endif
        @(negedge clk);
        chk1("after_done", done, 1'b0);
        chk1("after_busy", busy, 1'b0);
        chk8("after_sum", sum, es);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;

        // reset state, with start asserted while reset is still high
        @(negedge clk);
        start = 1'b1; a = 8'hAB; b = 8'hCD;
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk8("rst_sum", sum, 8'h00);
        chk1("rst_cout", cout, 1'b0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk1("idle_busy", busy, 1'b0);

        // basic additions
        run_op(8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0, 8'h00);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h08);
        run_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 8'h00);

        // starts during RUN are ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk1("ign_busy", busy, 1'b1);
            if (i == 2 || i == 4) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk1("ign_done", done, 1'b1);
        chk8("ign_sum", sum, 8'h30);
        chk1("ign_cout", cout, 1'b0);
        @(negedge clk);
        chk1("ign_idle", busy, 1'b0);

        // reset in the middle of RUN aborts the operation
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk1("pre_abort_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk8("abort_sum", sum, 8'h00);
        chk1("abort_cout", cout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk1("abort_no_done", done, 1'b0);
            @(negedge clk);
        end
        run_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00);

        // start held high: back-to-back operations
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h02; b = 8'h02;
        for (int i = 1; i <= 18; i++) begin
            if (i == 9 || i == 18) begin
                chk1("b2b_done", done, 1'b1);
                chk1("b2b_nbusy", busy, 1'b0);
                chk8("b2b_sum", sum, (i == 9) ? 8'h02 : 8'h04);
                if (i == 18) start = 1'b0;
            end else begin
                chk1("b2b_busy", busy, 1'b1);
                chk1("b2b_ndone", done, 1'b0);
                chk8("b2b_hold", sum, (i < 9) ? 8'hFF : 8'h02);
            end
            @(negedge clk);
        end
        chk1("b2b_idle_busy", busy, 1'b0);
        chk1("b2b_idle_done", done, 1'b0);
        chk8("b2b_final", sum, 8'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
